// File: rtl/paint_pkg.sv
// Shared constants, FSM encoding and colour field layout for the paint datapath
// (brush writer and VGA read side).
package paint_pkg;

  localparam int H_RES       = 640;
  localparam int V_RES       = 480;
  localparam int MAX_RADIUS  = 31;
  localparam int ADDR_W      = 20;
  localparam int COLOR_W     = 9;
  localparam int COORD_W     = 11;
  localparam int RADIUS_W    = 6;
  localparam int RAD_CLAMP_W = 5;

  // RGB333 field positions inside a pixel word
  localparam int RED_HI   = 8;
  localparam int RED_LO   = 6;
  localparam int GREEN_HI = 5;
  localparam int GREEN_LO = 3;
  localparam int BLUE_HI  = 2;
  localparam int BLUE_LO  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } stamp_state_t;

  function automatic logic [RAD_CLAMP_W-1:0] clamp_radius(input logic [RADIUS_W-1:0] rad);
    if (rad > RADIUS_W'(MAX_RADIUS))
      return RAD_CLAMP_W'(MAX_RADIUS);
    return rad[RAD_CLAMP_W-1:0];
  endfunction

endpackage

// File: rtl/brush_stamper_if.sv
// Cursor/brush request inputs and the frame-buffer write port of the brush stamper.
interface brush_stamper_if;
  import paint_pkg::*;

  logic [COORD_W-1:0]  x;
  logic [COORD_W-1:0]  y;
  logic [RADIUS_W-1:0] radius;
  logic                draw;
  logic [COLOR_W-1:0]  color;
  logic                enable_write_memory;
  logic [ADDR_W-1:0]   pos_pxl_w;
  logic [COLOR_W-1:0]  write_data;
  logic                busy;

  modport master (
    output x, y, radius, draw, color,
    input  enable_write_memory, pos_pxl_w, write_data, busy
  );

  modport slave (
    input  x, y, radius, draw, color,
    output enable_write_memory, pos_pxl_w, write_data, busy
  );

endinterface

// File: rtl/pixel_addr_calc.sv
// Screen bounds check and linear frame-buffer address for a signed pixel coordinate.
module pixel_addr_calc
  import paint_pkg::*;
(
  input  logic signed [11:0] px,
  input  logic signed [11:0] py,
  output logic               in_bounds,
  output logic [ADDR_W-1:0]  addr
);

  logic [ADDR_W-1:0] px_ext;
  logic [ADDR_W-1:0] py_ext;

  // 640 = 512 + 128, so the row multiply is two shifts and an add
  always_comb begin
    px_ext    = {{(ADDR_W-12){1'b0}}, px};
    py_ext    = {{(ADDR_W-12){1'b0}}, py};
    in_bounds = (px >= 0) && (px < H_RES) && (py >= 0) && (py < V_RES);
    addr      = (py_ext << 9) + (py_ext << 7) + px_ext;
  end

endmodule

// File: rtl/brush_stamper.sv
// Rasterises a filled disc around the cursor into frame-buffer writes,
// one candidate pixel per clock, whenever the brush is down and something changed.
module brush_stamper
  import paint_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  brush_stamper_if.slave bus
);

  stamp_state_t           state;
  logic [COORD_W-1:0]     cx;
  logic [COORD_W-1:0]     cy;
  logic [RAD_CLAMP_W-1:0] r;
  logic [COLOR_W-1:0]     col;
  logic                   stamped;
  logic signed [6:0]      dx;
  logic signed [6:0]      dy;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [COLOR_W-1:0]     data_q;
  logic                   busy_q;

  logic [RAD_CLAMP_W-1:0] req_r;
  logic signed [6:0]      r_s;
  logic signed [6:0]      neg_req_r;
  logic signed [13:0]     dx_w;
  logic signed [13:0]     dy_w;
  logic signed [13:0]     dx_sq;
  logic signed [13:0]     dy_sq;
  logic [13:0]            r_sq;
  logic [14:0]            dist_sq;
  logic signed [11:0]     px;
  logic signed [11:0]     py;
  logic                   in_bounds;
  logic [ADDR_W-1:0]      cand_addr;
  logic                   hit;
  logic                   changed;

  // Geometry of the current candidate relative to the latched brush
  always_comb begin
    req_r     = clamp_radius(bus.radius);
    r_s       = $signed({2'b00, r});
    neg_req_r = -$signed({2'b00, req_r});
    dx_w      = {{7{dx[6]}}, dx};
    dy_w      = {{7{dy[6]}}, dy};
    dx_sq     = dx_w * dx_w;
    dy_sq     = dy_w * dy_w;
    r_sq      = {9'd0, r} * {9'd0, r};
    dist_sq   = {1'b0, dx_sq} + {1'b0, dy_sq};
    px        = $signed({1'b0, cx}) + $signed({{5{dx[6]}}, dx});
    py        = $signed({1'b0, cy}) + $signed({{5{dy[6]}}, dy});
    hit       = in_bounds && (dist_sq <= {1'b0, r_sq});
    changed   = (bus.x != cx) || (bus.y != cy) || (req_r != r) || (bus.color != col);
  end

  pixel_addr_calc u_addr (
    .px        (px),
    .py        (py),
    .in_bounds (in_bounds),
    .addr      (cand_addr)
  );

  // Stamp FSM; the write port is registered so a hit surfaces one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cx      <= '0;
      cy      <= '0;
      r       <= '0;
      col     <= '0;
      stamped <= 1'b0;
      dx      <= '0;
      dy      <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we_q <= 1'b0;
          if (!bus.draw) begin
            stamped <= 1'b0;
          end else if (!stamped || changed) begin
            cx     <= bus.x;
            cy     <= bus.y;
            r      <= req_r;
            col    <= bus.color;
            dx     <= neg_req_r;
            dy     <= neg_req_r;
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          we_q <= hit;
          if (hit) begin
            addr_q <= cand_addr;
            data_q <= col;
          end
          if (dx == r_s) begin
            dx <= -r_s;
            if (dy == r_s)
              state <= DONE;
            else
              dy <= dy + 7'sd1;
          end else begin
            dx <= dx + 7'sd1;
          end
        end
        DONE: begin
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          stamped <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.enable_write_memory = we_q;
  assign bus.pos_pxl_w           = addr_q;
  assign bus.write_data          = data_q;
  assign bus.busy                = busy_q;

endmodule
